// File: rtl/vec_sub_acc16_if.sv
// vec_sub_acc16_if
// Job, operand and result signals of the packed-vector accumulator.
//   start/width/sub/len : job request and its latched configuration
//   in_valid/in_ready/inA : operand beat handshake and 16-bit packed operand
//   out_valid/out_ready/out : result handshake and 16-bit packed result
//   busy : accumulator is not idle
// master = job/operand source and result sink, slave = the accumulator.
interface vec_sub_acc16_if #(
    parameter int LEN_W = 8
);
    logic             start;
    logic             width;
    logic             sub;
    logic [LEN_W-1:0] len;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      inA;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out;
    logic             busy;

    modport master (
        output start, width, sub, len, in_valid, inA, out_ready,
        input  in_ready, out_valid, out, busy
    );

    modport slave (
        input  start, width, sub, len, in_valid, inA, out_ready,
        output in_ready, out_valid, out, busy
    );
endinterface

// File: rtl/vec_sub_acc16.sv
// vec_sub_acc16
// Sequential accumulator over a stream of packed 16-bit operands, running
// either one 16-bit lane or two independent 8-bit lanes. Each accepted beat
// adds the operand to, or subtracts it from, the running sum; after len beats
// the sum is presented through a valid/ready handshake.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : vec_sub_acc16_if slave (job, operand and result handshakes)
module vec_sub_acc16 #(
    parameter int LEN_W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    vec_sub_acc16_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [15:0]      acc;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] len_q;
    logic             width_q;
    logic             sub_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;

    logic [15:0]      op;
    logic [8:0]       lo_sum;
    logic             hi_cin;
    logic [7:0]       hi_sum;
    logic [15:0]      acc_next;
    logic [LEN_W-1:0] cnt_next;

    // Subtract is acc + ~inA + 1. The low lane always takes the +1; the high
    // lane takes either the low-lane carry (one 16-bit lane) or its own +1 in
    // subtract / 0 in add (two 8-bit lanes, carry chain broken at bit 8).
    always_comb begin
        op       = sub_q ? ~bus.inA : bus.inA;
        lo_sum   = {1'b0, acc[7:0]} + {1'b0, op[7:0]} + {8'd0, sub_q};
        hi_cin   = width_q ? sub_q : lo_sum[8];
        hi_sum   = acc[15:8] + op[15:8] + {7'd0, hi_cin};
        acc_next = {hi_sum, lo_sum[7:0]};
        cnt_next = cnt + LEN_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            acc         <= '0;
            cnt         <= '0;
            len_q       <= '0;
            width_q     <= 1'b0;
            sub_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        width_q <= bus.width;
                        sub_q   <= bus.sub;
                        len_q   <= bus.len;
                        acc     <= '0;
                        cnt     <= '0;
                        busy_q  <= 1'b1;
                        if (bus.len == '0) begin
                            state       <= DONE;
                            out_valid_q <= 1'b1;
                        end else begin
                            state      <= ACC;
                            in_ready_q <= 1'b1;
                        end
                    end
                end
                ACC: begin
                    // in_ready is always high here, so in_valid alone qualifies a beat
                    if (bus.in_valid) begin
                        acc <= acc_next;
                        cnt <= cnt_next;
                        if (cnt_next == len_q) begin
                            state       <= DONE;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.out       = acc;

endmodule
